// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, result error codes,
// FSM states and the AXI4 response/burst encodings it drives or decodes.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_ALIGN  = 2'd1;
    localparam logic [1:0] ERR_SLVERR = 2'd2;
    localparam logic [1:0] ERR_DECERR = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RADDR,
        ST_RDATA,
        ST_WRITE,
        ST_WRESP,
        ST_DONE
    } lsu_state_e;

    // A response from the wrong ID is treated as a decode error, whatever rresp/bresp said.
    function automatic logic [1:0] resp_to_err(input logic [1:0] resp, input logic id_ok);
        logic [1:0] err;
        err = ERR_OK;
        if (!id_ok) begin
            err = ERR_DECERR;
        end else if (resp == RESP_SLVERR) begin
            err = ERR_SLVERR;
        end else if (resp == RESP_DECERR) begin
            err = ERR_DECERR;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe placement, load lane
// extraction with sign/zero extension, and the alignment/size legality check.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          addr_lo,
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [DATA_W-1:0]   st_data,
    output logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_wstrb,
    input  logic [DATA_W-1:0]   ld_raw,
    output logic [DATA_W-1:0]   ld_data,
    output logic                align_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [OFF_W-1:0]  offset;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;

    assign offset = addr_lo[OFF_W-1:0];

    always_comb begin
        strb_base = '0;
        case (size)
            SIZE_B:  strb_base = STRB_W'(8'h01);
            SIZE_H:  strb_base = STRB_W'(8'h03);
            SIZE_W:  strb_base = STRB_W'(8'h0F);
            default: strb_base = STRB_W'(8'hFF);
        endcase
        st_wstrb = strb_base << offset;
        st_wdata = st_data << {offset, 3'b000};
    end

    always_comb begin
        shifted   = ld_raw >> {offset, 3'b000};
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size)
            SIZE_B: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            SIZE_H: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            SIZE_W: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = shifted[DATA_W-1];
            end
        endcase
        ld_data = shifted & keep_mask;
        if (sign_bit && !is_unsigned) begin
            ld_data = ld_data | ~keep_mask;
        end
    end

    // A dword access is illegal outright on a 32-bit bus, otherwise it must be 8-aligned.
    always_comb begin
        align_err = 1'b0;
        case (size)
            SIZE_B:  align_err = 1'b0;
            SIZE_H:  align_err = addr_lo[0];
            SIZE_W:  align_err = |addr_lo[1:0];
            default: align_err = (DATA_W < 64) || (|addr_lo);
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store unit: one EX operation becomes one single-beat
// AXI4 read or write after winning the shared bus, and the result goes to WB.
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int LSU_ID = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_rd,
    input  logic                in_wr,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic [1:0]          out_err,
    output logic                bus_req,
    input  logic                bus_grant,
    output logic [ADDR_W-1:0]   araddr,
    output logic [ID_W-1:0]     arid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic [ID_W-1:0]     rid,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [ID_W-1:0]     awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic [ID_W-1:0]     bid,
    input  logic                bvalid,
    output logic                bready
);

    localparam int              STRB_W = DATA_W / 8;
    localparam logic [ID_W-1:0] MY_ID  = ID_W'(LSU_ID);

    lsu_state_e state_q, state_d;

    logic                is_load_q, is_load_d;
    logic [2:0]          addr_lo_q, addr_lo_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   out_rdata_q, out_rdata_d;
    logic [1:0]          out_err_q, out_err_d;

    logic [2:0]          al_addr;
    logic [1:0]          al_size;
    logic                al_uns;
    logic [DATA_W-1:0]   al_wdata;
    logic [STRB_W-1:0]   al_wstrb;
    logic [DATA_W-1:0]   al_ld_data;
    logic                al_err;
    logic [1:0]          r_err;
    logic [1:0]          b_err;
    logic                unused_rlast;

    // The aligner checks the incoming request while idle and the latched one afterwards.
    assign al_addr = (state_q == ST_IDLE) ? in_addr[2:0] : addr_lo_q;
    assign al_size = (state_q == ST_IDLE) ? in_size : size_q;
    assign al_uns  = (state_q == ST_IDLE) ? in_unsigned : uns_q;

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .addr_lo     (al_addr),
        .size        (al_size),
        .is_unsigned (al_uns),
        .st_data     (in_wdata),
        .st_wdata    (al_wdata),
        .st_wstrb    (al_wstrb),
        .ld_raw      (rdata),
        .ld_data     (al_ld_data),
        .align_err   (al_err)
    );

    assign r_err        = resp_to_err(rresp, rid == MY_ID);
    assign b_err        = resp_to_err(bresp, bid == MY_ID);
    assign unused_rlast = rlast;

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    is_load_d   = in_rd;
                    addr_lo_d   = in_addr[2:0];
                    size_d      = in_size;
                    uns_d       = in_unsigned;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    out_rdata_d = '0;
                    out_err_d   = ERR_OK;
                    if (!in_rd && !in_wr) begin
                        state_d = ST_DONE;
                    end else if (al_err) begin
                        out_err_d = ERR_ALIGN;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                        if (in_rd) begin
                            araddr_d = in_addr;
                        end else begin
                            awaddr_d = in_addr;
                            wdata_d  = al_wdata;
                            wstrb_d  = al_wstrb;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (bus_grant) begin
                    state_d = is_load_q ? ST_RADDR : ST_WRITE;
                end
            end
            ST_RADDR: begin
                if (arready) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (rvalid) begin
                    out_err_d   = r_err;
                    out_rdata_d = (r_err == ERR_OK) ? al_ld_data : '0;
                    state_d     = ST_DONE;
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; leave once both have handshaken.
                if (awready) begin
                    aw_done_d = 1'b1;
                end
                if (wready) begin
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bvalid) begin
                    out_err_d = b_err;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            is_load_q   <= 1'b0;
            addr_lo_q   <= '0;
            size_q      <= SIZE_B;
            uns_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            out_rdata_q <= '0;
            out_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
        end
    end

    // The bus stays requested from REQ until the R or B handshake retires the access.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign bus_req   = (state_q == ST_REQ)   || (state_q == ST_RADDR) ||
                       (state_q == ST_RDATA) || (state_q == ST_WRITE) ||
                       (state_q == ST_WRESP);
    assign arvalid   = (state_q == ST_RADDR);
    assign rready    = (state_q == ST_RDATA);
    assign awvalid   = (state_q == ST_WRITE) && !aw_done_q;
    assign wvalid    = (state_q == ST_WRITE) && !w_done_q;
    assign bready    = (state_q == ST_WRESP);

    assign out_rdata = out_rdata_q;
    assign out_err   = out_err_q;
    assign araddr    = araddr_q;
    assign awaddr    = awaddr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign arsize    = {1'b0, size_q};
    assign awsize    = {1'b0, size_q};
    assign arid      = MY_ID;
    assign awid      = MY_ID;
    assign arlen     = 8'd0;
    assign awlen     = 8'd0;
    assign arburst   = BURST_INCR;
    assign awburst   = BURST_INCR;
    assign wlast     = 1'b1;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master (DATA_W=32): directed scenarios plus
// randomized loads/stores checked against a byte-level reference model.
module tb_lsu_axi_master;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int LSU_ID = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, in_rd, in_wr, in_unsigned;
    logic [31:0] in_addr, in_wdata;
    logic [1:0]  in_size;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;
    logic        bus_req, bus_grant;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arid, awid, rid, bid, wstrb;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    // slave knobs
    int          g_dly, ar_dly, r_dly, aw_dly, w_dly, b_dly, rdy_dly;
    logic        hold_grant;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [3:0]  s_id;

    // slave bookkeeping and observations
    int          gcnt, acnt, rcnt, awcnt, wcnt, bcnt, proto_errs;
    logic        prev_arvalid, prev_arready, prev_awvalid, prev_awready, prev_wvalid, prev_wready;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata;
    logic [3:0]  prev_wstrb;
    logic        saw_bus, obs_accept, obs_stable, obs_after, obs_timeout;
    int          obs_lat;
    logic [31:0] obs_rdata, obs_araddr, obs_awaddr, obs_wdata;
    logic [1:0]  obs_err;
    logic [2:0]  obs_arsize, obs_awsize;
    logic [3:0]  obs_wstrb;

    always #5 clk = ~clk;

    lsu_axi_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LSU_ID(LSU_ID)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wr(in_wr),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] v;
        int nb, off;
        nb  = 1 << size;
        off = int'(addr % 4);
        v   = (64'(word) >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
        if (!uns && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] s;
        int off;
        s   = 4'b0;
        off = int'(addr % 4);
        for (int i = 0; i < (1 << size); i++) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic m_bad(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [1:0] size);
        if (!rd && !wr) return 1'b0;
        if (size == 2'd3) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [1:0] m_err(input logic rd, input logic wr, input logic [31:0] addr,
                                         input logic [1:0] size, input logic [1:0] resp,
                                         input logic [3:0] id);
        if (!rd && !wr) return 2'd0;
        if (m_bad(rd, wr, addr, size)) return 2'd1;
        if (id != 4'(LSU_ID)) return 2'd3;
        if (resp >= 2'd2) return resp;
        return 2'd0;
    endfunction

    function automatic int m_lat(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size);
        int g;
        g = hold_grant ? 0 : g_dly;
        if (!rd && !wr) return 1;
        if (m_bad(rd, wr, addr, size)) return 1;
        if (rd) return 4 + g + ar_dly + r_dly;
        return 4 + g + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    endfunction

    // ---------------- bus slave / driver ----------------
    task automatic slave_clear();
        bus_grant = hold_grant;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    endtask

    task automatic knobs_default();
        g_dly = 0; ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; rdy_dly = 0;
        hold_grant = 0; s_rdata = 0; s_resp = 0; s_id = 4'(LSU_ID);
    endtask

    task automatic slave_step();
        if (bus_req || arvalid || awvalid || wvalid) saw_bus = 1'b1;
        if (prev_arvalid && !prev_arready && (arvalid !== 1'b1 || araddr !== prev_araddr)) proto_errs++;
        if (prev_awvalid && !prev_awready && (awvalid !== 1'b1 || awaddr !== prev_awaddr)) proto_errs++;
        if (prev_wvalid && !prev_wready &&
            (wvalid !== 1'b1 || wdata !== prev_wdata || wstrb !== prev_wstrb)) proto_errs++;
        if (bus_req) gcnt++;
        bus_grant = hold_grant || (bus_req && gcnt > g_dly);
        if (arvalid) begin acnt++; obs_araddr = araddr; obs_arsize = arsize; end
        arready = arvalid && (acnt > ar_dly);
        if (rready) rcnt++;
        rvalid = rready && (rcnt > r_dly);
        rdata  = rvalid ? s_rdata : 32'h0;
        rresp  = s_resp; rid = s_id; rlast = 1'b1;
        if (awvalid) begin awcnt++; obs_awaddr = awaddr; obs_awsize = awsize; end
        awready = awvalid && (awcnt > aw_dly);
        if (wvalid) begin wcnt++; obs_wdata = wdata; obs_wstrb = wstrb; end
        wready = wvalid && (wcnt > w_dly);
        if (bready) bcnt++;
        bvalid = bready && (bcnt > b_dly);
        bresp  = s_resp; bid = s_id;
        prev_arvalid = arvalid; prev_arready = arready; prev_araddr = araddr;
        prev_awvalid = awvalid; prev_awready = awready; prev_awaddr = awaddr;
        prev_wvalid  = wvalid;  prev_wready  = wready;  prev_wdata  = wdata; prev_wstrb = wstrb;
    endtask

    task automatic obs_init();
        gcnt = 0; acnt = 0; rcnt = 0; awcnt = 0; wcnt = 0; bcnt = 0; proto_errs = 0;
        prev_arvalid = 0; prev_arready = 0; prev_awvalid = 0; prev_awready = 0;
        prev_wvalid = 0; prev_wready = 0; prev_araddr = 0; prev_awaddr = 0;
        prev_wdata = 0; prev_wstrb = 0;
        saw_bus = 0; obs_stable = 1; obs_after = 0; obs_timeout = 0; obs_lat = -1;
        obs_rdata = 0; obs_err = 0; obs_araddr = 0; obs_awaddr = 0; obs_wdata = 0;
        obs_wstrb = 0; obs_arsize = 0; obs_awsize = 0;
    endtask

    // Drives one operation, plays the bus slave, records latency from the accepting edge (T0).
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic uns);
        obs_init();
        @(negedge clk);
        slave_clear();
        obs_accept = in_ready;
        in_valid = 1; in_rd = rd; in_wr = wr; in_addr = addr; in_wdata = wd;
        in_size = size; in_unsigned = uns;
        @(posedge clk);
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 0;
            if (out_valid === 1'b1) begin
                obs_lat = k; obs_rdata = out_rdata; obs_err = out_err;
                break;
            end
            slave_step();
        end
        slave_clear();
        if (obs_lat < 0) begin
            obs_timeout = 1;
        end else begin
            for (int h = 0; h < rdy_dly; h++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_rdata !== obs_rdata || out_err !== obs_err ||
                    in_ready !== 1'b0) obs_stable = 0;
            end
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
            obs_after = out_valid;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 0; in_valid = 0; in_rd = 0; in_wr = 0; in_addr = 0; in_wdata = 0;
        in_size = 0; in_unsigned = 0; out_ready = 0;
        knobs_default();
        slave_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        checks++; if ({out_valid, bus_req, arvalid, awvalid, wvalid, rready, bready} !== 7'b0) begin
            errors++; $display("FAIL reset valids got %b want 0", {out_valid, bus_req, arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if ({out_rdata, out_err, araddr, awaddr, wdata, wstrb} !== 134'b0) begin
            errors++; $display("FAIL reset payload got %h %h %h %h %h %h want 0", out_rdata, out_err, araddr, awaddr, wdata, wstrb); end
        checks++; if ({arid, awid, arlen, awlen, arburst, awburst, wlast} !== {4'd1, 4'd1, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1}) begin
            errors++; $display("FAIL reset axi_fields got %h %h %h %h %h %h %b", arid, awid, arlen, awlen, arburst, awburst, wlast); end
        rstn = 1;
        $display("reset: checked reset outputs");
    endtask

    task automatic test_word_load();
        knobs_default();
        s_rdata = 32'hDEAD_BEEF;
        run_op(1, 0, 32'h8000_0004, 32'h0, 2'd2, 0);
        $display("word_load: lat=%0d rdata=%h err=%0d arsize=%0d", obs_lat, obs_rdata, obs_err, obs_arsize);
        checks++; if (obs_accept !== 1'b1) begin errors++; $display("FAIL word_load in_ready got %b want 1", obs_accept); end
        checks++; if (obs_lat !== 4) begin errors++; $display("FAIL word_load latency got %0d want 4", obs_lat); end
        checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load rdata got %h want deadbeef", obs_rdata); end
        checks++; if (obs_err !== 2'd0) begin errors++; $display("FAIL word_load err got %0d want 0", obs_err); end
        checks++; if (obs_arsize !== 3'd2 || obs_araddr !== 32'h8000_0004) begin
            errors++; $display("FAIL word_load ar got size %0d addr %h want 2 80000004", obs_arsize, obs_araddr); end
        checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL word_load out_valid_after_pop got %b want 0", obs_after); end
    endtask

    task automatic test_byte_load();
        for (int u = 0; u < 2; u++) begin
            knobs_default();
            s_rdata = 32'h80AB_CDEF;
            run_op(1, 0, 32'h8000_0003, 32'h0, 2'd0, u[0]);
            $display("byte_load uns=%0d: rdata=%h err=%0d", u, obs_rdata, obs_err);
            checks++; if (obs_rdata !== (u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080)) begin
                errors++; $display("FAIL byte_load uns=%0d rdata got %h want %h", u, obs_rdata, (u == 0 ? 32'hFFFF_FF80 : 32'h80)); end
        end
    endtask

    task automatic test_half_store();
        knobs_default();
        aw_dly = 2; w_dly = 0;
        run_op(0, 1, 32'h1000_0002, 32'h0000_1234, 2'd1, 0);
        $display("half_store: lat=%0d wdata=%h wstrb=%b err=%0d", obs_lat, obs_wdata, obs_wstrb, obs_err);
        checks++; if (obs_wdata !== 32'h1234_0000) begin errors++; $display("FAIL half_store wdata got %h want 12340000", obs_wdata); end
        checks++; if (obs_wstrb !== 4'b1100) begin errors++; $display("FAIL half_store wstrb got %b want 1100", obs_wstrb); end
        checks++; if (obs_lat !== 6) begin errors++; $display("FAIL half_store latency got %0d want 6", obs_lat); end
        checks++; if (obs_err !== 2'd0 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL half_store result got err %0d rdata %h want 0 0", obs_err, obs_rdata); end
        checks++; if (proto_errs !== 0) begin errors++; $display("FAIL half_store protocol got %0d want 0", proto_errs); end
    endtask

    task automatic test_short_ops();
        knobs_default();
        hold_grant = 1;  // a grant visible in IDLE must not start a bus access
        run_op(1, 0, 32'h8000_0001, 32'h0, 2'd2, 0);
        $display("misaligned: lat=%0d err=%0d saw_bus=%b", obs_lat, obs_err, saw_bus);
        checks++; if (obs_lat !== 1 || obs_err !== 2'd1) begin
            errors++; $display("FAIL misaligned got lat %0d err %0d want 1 1", obs_lat, obs_err); end
        checks++; if (saw_bus !== 1'b0) begin errors++; $display("FAIL misaligned bus_activity got %b want 0", saw_bus); end
        knobs_default();
        run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 0);
        $display("pass_through: lat=%0d err=%0d rdata=%h", obs_lat, obs_err, obs_rdata);
        checks++; if (obs_lat !== 1 || obs_err !== 2'd0 || obs_rdata !== 32'h0 || saw_bus !== 1'b0) begin
            errors++; $display("FAIL pass_through got lat %0d err %0d rdata %h bus %b want 1 0 0 0", obs_lat, obs_err, obs_rdata, saw_bus); end
    endtask

    task automatic test_bus_errors();
        knobs_default();
        s_resp = 2'b10; s_rdata = 32'h1111_2222;
        run_op(1, 0, 32'h2000_0000, 32'h0, 2'd2, 0);
        $display("slverr_load: err=%0d rdata=%h", obs_err, obs_rdata);
        checks++; if (obs_err !== 2'd2) begin errors++; $display("FAIL slverr err got %0d want 2", obs_err); end
        knobs_default();
        s_id = 4'd5; rdy_dly = 5;
        run_op(0, 1, 32'h2000_0008, 32'hCAFE_F00D, 2'd2, 0);
        $display("bid_mismatch: err=%0d stable=%b", obs_err, obs_stable);
        checks++; if (obs_err !== 2'd3) begin errors++; $display("FAIL bid_mismatch err got %0d want 3", obs_err); end
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", obs_stable); end
    endtask

    task automatic test_reset_mid();
        logic found;
        knobs_default();
        r_dly = 20;
        obs_init();
        found = 0;
        @(negedge clk);
        slave_clear();
        in_valid = 1; in_rd = 1; in_wr = 0; in_addr = 32'h3000_0000; in_size = 2'd2; in_unsigned = 0;
        @(posedge clk);
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            in_valid = 0;
            if (rready === 1'b1) begin found = 1; break; end
            slave_step();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL reset_mid reach_rdata got %b want 1", found); end
        slave_clear();
        rstn = 0;
        @(posedge clk);
        #1;
        $display("reset_mid: rready=%b bus_req=%b out_valid=%b", rready, bus_req, out_valid);
        checks++; if ({rready, bus_req, out_valid, arvalid} !== 4'b0) begin
            errors++; $display("FAIL reset_mid outputs got %b want 0000", {rready, bus_req, out_valid, arvalid}); end
        rstn = 1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid stray out_valid got %b want 0", out_valid); end
        knobs_default();
        s_rdata = 32'h0BAD_F00D;
        run_op(1, 0, 32'h3000_0004, 32'h0, 2'd2, 0);
        $display("after_reset_load: lat=%0d rdata=%h", obs_lat, obs_rdata);
        checks++; if (obs_lat !== 4 || obs_rdata !== 32'h0BAD_F00D || obs_err !== 2'd0) begin
            errors++; $display("FAIL after_reset_load got lat %0d rdata %h err %0d want 4 0badf00d 0", obs_lat, obs_rdata, obs_err); end
    endtask

    task automatic test_random();
        logic        rd, wr, uns;
        logic [31:0] addr, wd;
        logic [1:0]  size;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        for (int n = 0; n < 60; n++) begin
            knobs_default();
            rd = $urandom_range(0, 3) != 0; wr = $urandom_range(0, 2) == 0;
            if (!rd && $urandom_range(0, 1) == 1) wr = 1;
            addr = $urandom; size = 2'($urandom_range(0, 3)); uns = 1'($urandom);
            if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            wd = $urandom;
            g_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            rdy_dly = $urandom_range(0, 2); hold_grant = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            s_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            s_id = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'(LSU_ID);
            exp_err   = m_err(rd, wr, addr, size, s_resp, s_id);
            exp_rdata = (rd && exp_err == 2'd0) ? m_load(s_rdata, addr, size, uns) : 32'h0;
            exp_lat   = m_lat(rd, wr, addr, size);
            run_op(rd, wr, addr, wd, size, uns);
            $display("rand %0d: rd=%b wr=%b addr=%h size=%0d lat=%0d/%0d err=%0d/%0d rdata=%h/%h",
                     n, rd, wr, addr, size, obs_lat, exp_lat, obs_err, exp_err, obs_rdata, exp_rdata);
            checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rand%0d latency got %0d want %0d", n, obs_lat, exp_lat); end
            checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rand%0d err got %0d want %0d", n, obs_err, exp_err); end
            checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rand%0d rdata got %h want %h", n, obs_rdata, exp_rdata); end
            checks++; if (obs_stable !== 1'b1 || obs_after !== 1'b0 || proto_errs !== 0) begin
                errors++; $display("FAIL rand%0d handshake got stable %b after %b proto %0d want 1 0 0", n, obs_stable, obs_after, proto_errs); end
            if (exp_lat == 1) begin
                checks++; if (saw_bus !== 1'b0) begin errors++; $display("FAIL rand%0d bus_activity got %b want 0", n, saw_bus); end
            end else if (rd) begin
                checks++; if (obs_araddr !== addr || obs_arsize !== {1'b0, size}) begin
                    errors++; $display("FAIL rand%0d ar got %h %0d want %h %0d", n, obs_araddr, obs_arsize, addr, size); end
            end else begin
                checks++; if (obs_awaddr !== addr || obs_awsize !== {1'b0, size} ||
                              obs_wdata !== (wd << (8 * (addr % 4))) || obs_wstrb !== m_strb(addr, size)) begin
                    errors++; $display("FAIL rand%0d aw/w got %h %0d %h %b want %h %0d %h %b", n, obs_awaddr, obs_awsize,
                                       obs_wdata, obs_wstrb, addr, size, wd << (8 * (addr % 4)), m_strb(addr, size)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_short_ops();
        test_bus_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_axi_master.md
# lsu_axi_master

Parametrised load/store unit, second generation: accepts one memory operation at a time from the execute stage and performs it as a single-beat AXI4 read or write. It generalises data width, transaction ID and access size, derives byte lanes from the address, and sign/zero-extends loads. It reports misalignment and bus errors, and arbitrates for the shared bus via req/grant. It sits between the EX and WB stages, in the same position as the current LSU, and drives the SoC-side AXI4 master port.

## Interface
- DATA_W, 32 — data bus width, 32 or 64
- ADDR_W, 32 — address width
- ID_W, 4 — AXI ID width
- LSU_ID, 1 — value driven on arid/awid; expected on rid/bid
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_valid / in_ready  in / out  1  operation handshake from EX
- in_rd, in_wr  in  1  load / store; both 0 = pass-through; both 1 is illegal and treated as a load
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data, right-aligned
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64)
- in_unsigned  in  1  zero-extend load
- out_valid / out_ready  out / in  1  result handshake to WB
- out_rdata  out  DATA_W  extended load data; 0 for stores and pass-through
- out_err  out  2  0 ok, 1 misaligned or illegal size, 2 SLVERR, 3 DECERR or ID mismatch
- bus_req / bus_grant  out / in  1  shared-bus arbitration
- AXI4 AR: araddr, arid, arlen, arsize, arburst, arvalid (out); arready (in)
- AXI4 R: rdata, rresp, rlast, rid, rvalid (in); rready (out)
- AXI4 AW: awaddr, awid, awlen, awsize, awburst, awvalid (out); awready (in)
- AXI4 W: wdata, wstrb (DATA_W/8), wlast, wvalid (out); wready (in)
- AXI4 B: bresp, bid, bvalid (in); bready (out)

## Operation
- States: IDLE, REQ, RADDR, RDATA, WRITE, WRESP, DONE.
- IDLE: in_ready=1. On in_valid, latch all inputs.
  - Pass-through, misaligned address, or illegal size: go to DONE with the matching out_err.
  - Legal load or store: go to REQ.
- REQ: bus_req=1. On bus_grant: load → RADDR, store → WRITE. bus_req stays 1 until the R or B handshake completes.
- RADDR: arvalid=1 until arready. Then RDATA with rready=1.
- RDATA: on rvalid, shift the selected lanes down by addr[log2(DATA_W/8)-1:0]*8, then extend per in_size/in_unsigned.
  - rresp[1]=1 → out_err 2 (resp 2) or 3 (resp 3).
  - rid≠LSU_ID → out_err 3.
- WRITE: awvalid and wvalid both asserted. Each drops on its own handshake; AW and W may complete in either order or the same cycle. When both are done → WRESP with bready=1.
  - wdata = in_wdata << offset*8.
  - wstrb = ((1<<(1<<in_size))-1) << offset.
- WRESP: on bvalid → DONE. Errors are mapped as for R.
- AXI field values: arlen=awlen=0, arburst=awburst=INCR, wlast=1, arsize=awsize=in_size, addresses unmodified.
- DONE: out_valid=1 and holds until out_ready, then IDLE. out_rdata and out_err stay stable while out_valid=1.
- Reset values: in_ready=1. All valids, bus_req, rready and bready 0. out_rdata, out_err, wdata, wstrb, araddr and awaddr 0. arid=awid=LSU_ID, lens 0, bursts INCR.
- Reset asserted mid-transaction aborts it. Valids drop at the next edge and no out_valid is produced.

## Timing
- Pass-through or error: out_valid on the edge after acceptance (1-cycle latency).
- Load with zero-wait grant, arready and rvalid: accept T0, REQ T1, RADDR T2, RDATA T3, out_valid T4.
- Store, best case: out_valid T4, same cycle shape as a load.
- bus_grant is sampled only in REQ. A grant seen in IDLE is ignored.
- AXI valid signals never drop before their handshake, and payloads are stable while valid.
- A new operation is accepted only in IDLE. No pipelining; at most one transaction is outstanding.

## Structure
- Shared package lsu_pkg holds:
  - size encodings
  - out_err codes
  - FSM state enum
  - AXI resp and burst constants (OKAY, SLVERR, DECERR, INCR)
- Sub-module lsu_lane_align (combinational), parametrised on DATA_W:
  - store path: wdata/wstrb generation
  - load path: lane extraction plus sign/zero extension
  - misalignment check
- The top module holds the FSM, input latches and AXI registers.

## Test plan
- Word load, addr 0x8000_0004, DATA_W=32, grant/arready/rvalid immediate, rdata 0xDEAD_BEEF → arsize 2, out_rdata 0xDEAD_BEEF, out_err 0, out_valid at T4.
- Signed byte load, addr 0x…3, rdata 0x80xx_xxxx → out_rdata 0xFFFF_FF80. With in_unsigned=1 → 0x0000_0080.
- Half store, addr 0x…2, in_wdata 0x1234 → wdata 0x1234_0000, wstrb 4'b1100. W handshake two cycles before AW still reaches DONE after B.
- Misaligned word load, addr 0x…1 → no arvalid or bus_req, out_err 1 at T1.
- rresp=SLVERR → out_err 2. bid≠LSU_ID → out_err 3. With out_ready held low 5 cycles, out_valid and data stay stable and in_ready stays 0.
- rstn low during RDATA → rready, bus_req and out_valid are 0 after the edge. The next load completes normally.
